// File: rtl/csa_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIB_W   : width of one carry_select slice pass (bits)
//   state_t : controller state encoding (IDLE/RUN/DONE)
package csa_pkg;
   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/carry_select.sv
// 4-bit carry-select adder slice: {cout,s} = x + y + carry.
// Both carry-in outcomes are precomputed and the incoming carry picks one.
//   x, y  : 4-bit operands
//   carry : carry-in
//   s     : 4-bit sum
//   cout  : carry-out
module carry_select
   import csa_pkg::*;
(
   input  logic [NIB_W-1:0] x,
   input  logic [NIB_W-1:0] y,
   input  logic             carry,
   output logic [NIB_W-1:0] s,
   output logic             cout
);
   logic [NIB_W:0] sum0;
   logic [NIB_W:0] sum1;

   assign sum0        = {1'b0, x} + {1'b0, y};
   assign sum1        = sum0 + {{NIB_W{1'b0}}, 1'b1};
   assign {cout, s}   = carry ? sum1 : sum0;
endmodule

// File: rtl/nibble_serial_adder.sv
// Sequential WIDTH-bit adder that streams operands through a single 4-bit
// carry_select slice, one nibble per clock, least-significant nibble first.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : operand handshake (x, y, carry captured on accept)
//   out_valid/out_ready : result handshake (s, cout held while out_valid)
//   s, cout             : registered WIDTH-bit sum and final carry-out
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_adder
   import csa_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout
);
   localparam int NIBBLES = WIDTH / NIB_W;
   localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   state_t             state;
   logic [WIDTH-1:0]   op_x;
   logic [WIDTH-1:0]   op_y;
   logic [WIDTH-1:0]   work;
   logic               c_reg;
   logic [CNT_W-1:0]   nib_cnt;

   logic [WIDTH-1:0]   x_sh;
   logic [WIDTH-1:0]   y_sh;
   logic [WIDTH-1:0]   work_next;
   logic [NIB_W-1:0]   nib_s;
   logic               nib_c;
   logic               last_nib;

   // Shifting the current nibble down to bit 0 keeps the slice select free
   // of variable part-selects, which also covers the single-nibble case.
   assign x_sh = op_x >> (NIB_W * int'(nib_cnt));
   assign y_sh = op_y >> (NIB_W * int'(nib_cnt));

   carry_select u_slice (
      .x     (x_sh[NIB_W-1:0]),
      .y     (y_sh[NIB_W-1:0]),
      .carry (c_reg),
      .s     (nib_s),
      .cout  (nib_c)
   );

   // work is cleared on accept and each nibble is written exactly once,
   // so OR-ing the shifted slice sum in place is a plain nibble insert.
   assign work_next = work | (WIDTH'(nib_s) << (NIB_W * int'(nib_cnt)));
   assign last_nib  = (nib_cnt == CNT_W'(NIBBLES - 1));
   assign in_ready  = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_x      <= '0;
         op_y      <= '0;
         work      <= '0;
         c_reg     <= 1'b0;
         nib_cnt   <= '0;
         s         <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_x    <= x;
                  op_y    <= y;
                  c_reg   <= carry;
                  work    <= '0;
                  nib_cnt <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               work  <= work_next;
               c_reg <= nib_c;
               if (last_nib) begin
                  // Result becomes visible only here; s/cout hold the
                  // previous result for the whole RUN phase.
                  s         <= work_next;
                  cout      <= nib_c;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  nib_cnt <= nib_cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Sequential wide adder that streams WIDTH-bit operands through the team's existing 4-bit carry_select slice, one nibble per clock, least-significant nibble first. Stage carry is registered between nibbles. The block feeds each x/y/carry slice into carry_select and consumes its s/cout, assembling the full-width result. Valid/ready handshakes on both sides let it sit between an operand source and a result consumer in the datapath.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of 4 and at least 4.
NIBBLES, WIDTH/4, derived number of slice passes; not overridden.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand source has x, y and carry valid.
in_ready  output  1  block can accept operands; high only in IDLE.
x  input  WIDTH  operand A, captured on the input handshake.
y  input  WIDTH  operand B, captured on the input handshake.
carry  input  1  carry-in, captured on the input handshake.
out_valid  output  1  s and cout hold a completed result.
out_ready  input  1  consumer accepts the result.
s  output  WIDTH  registered sum.
cout  output  1  registered carry-out of the top nibble.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE; s=0, cout=0, out_valid=0.
  - Internal operand, work and carry registers and the nibble counter are cleared.
  - in_ready=1, because it is decoded from IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a rising edge: capture x, y, carry; nib_cnt=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each edge, drive carry_select with x[4*nib_cnt+:4], y[4*nib_cnt+:4] and the carry register.
  - Store the slice s into work[4*nib_cnt+:4]; carry register <= slice cout; nib_cnt++.
  - On the edge where nib_cnt==NIBBLES-1: load s <= completed work word, cout <= slice cout, out_valid <= 1; go to DONE.
- DONE:
  - out_valid=1; s and cout held stable.
  - On out_ready at an edge: out_valid <= 0; go to IDLE.
  - in_ready=0 throughout DONE, so there is no overlap of transactions.
- Latency: input handshake at edge k gives out_valid high immediately after edge k+NIBBLES. Examples: WIDTH=16 gives 4 edges; WIDTH=4 gives 1 edge.
- Throughput: at most one result per NIBBLES+2 cycles when out_ready is tied high.
- Arithmetic: {cout,s} = x + y + carry, modulo 2^(WIDTH+1). Carry ripples only through the registered carry between nibbles.
- s and cout keep the previous result while RUN computes into the work register. They change only on entry to DONE or on reset.
- in_valid while not in IDLE is ignored; the source must hold operands until in_ready.
- out_ready while not in DONE has no effect.
- Reset mid-RUN or mid-DONE aborts and discards the transaction; no partial result becomes visible.
- nib_cnt is $clog2(NIBBLES) bits, minimum 1. It never wraps past NIBBLES-1.

Decomposition:
- Shared package/header (csa_pkg): NIB_W=4 and the state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- One sub-module instance: the existing carry_select (4-bit x, y, carry -> s, cout), used unmodified.
- The FSM, counter, carry register and result assembly live in nibble_serial_adder.

Test Plan:
1. WIDTH=16, x=0x0001, y=0x0006, carry=0, out_ready=1 -> out_valid exactly 4 edges after accept; s=0x0007, cout=0.
2. WIDTH=16, full carry propagation: x=0xFFFF, y=0x0000, carry=1 -> s=0x0000, cout=1. Then x=0xA5A5, y=0x5A5A, carry=0 -> s=0xFFFF, cout=0.
3. WIDTH=16, back-to-back: x=0x1239, y=0x0002, carry=1 -> s=0x123C. Next x=0x0005, y=0x0001, carry=1 -> s=0x0007. in_ready must be low in RUN/DONE and high again one edge after the out handshake.
4. Backpressure: hold out_ready=0 for 6 cycles after out_valid, with in_valid=1 and new operands on the inputs -> s/cout stable, in_ready=0, nothing accepted. Release out_ready -> IDLE, then the new operands are accepted.
5. Reset mid-operation: assert rst_n=0 after 2 RUN edges of x=0xFFFF, y=0x0001 -> s=0, cout=0, out_valid=0, in_ready=1 immediately (asynchronous). After release, x=0x0100, y=0x0200, carry=0 -> s=0x0300.
6. WIDTH=4 instance: x=0x9, y=0x2, carry=1 -> s=0xC, cout=0. x=0xD, y=0x2, carry=0 -> s=0xF, cout=0. x=0x7, y=0x9, carry=1 -> s=0x1, cout=1. Latency 1 edge each.
